// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/sub datapath: FSM state encoding
// and the digit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Never returns 0, so a single-digit configuration still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_digit.sv
// full_add cell and the DIGIT-bit ripple adder built from it; also exposes
// the carry into the top bit so the caller can form signed overflow.
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb_in
);
  // Per-bit carry nets live in each generate scope to keep the chain acyclic.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_first
      assign c_in = ci;
    end else begin : g_rest
      assign c_in = g_bit[i-1].c_out;
    end
    full_add u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c_in),
      .s  (sum[i]),
      .co (c_out)
    );
  end

  assign co       = g_bit[DIGIT-1].c_out;
  assign c_msb_in = g_bit[DIGIT-1].c_in;
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSD first, with valid/ready on both operand and result sides.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  localparam logic [1:0]    IDLE = ST_IDLE;
  localparam logic [1:0]    RUN  = ST_RUN;
  localparam logic [1:0]    HOLD = ST_HOLD;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0] dsum;
  logic             dco, dmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .sum      (dsum),
    .co       (dco),
    .c_msb_in (dmsb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // New digit enters at the top; after NDIG shifts the LSD has reached bit 0.
    res_d = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dco;
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q    <= res_d;
            cout_q <= dco;
            ovf_q  <= dco ^ dmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: WIDTH=8/DIGIT=1 directed, backpressure, reset and random
// tests, plus an exhaustive WIDTH=4 sweep at DIGIT=1,2,4.
module tb_serial_addsub;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  serial_addsub_if #(.WIDTH(8)) i8 ();
  serial_addsub_if #(.WIDTH(4)) i41 ();
  serial_addsub_if #(.WIDTH(4)) i42 ();
  serial_addsub_if #(.WIDTH(4)) i44 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_addsub #(.WIDTH(4), .DIGIT(1)) u41 (.clk(clk), .rst_n(rst_n), .bus(i41));
  serial_addsub #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst_n(rst_n), .bus(i42));
  serial_addsub #(.WIDTH(4), .DIGIT(4)) u44 (.clk(clk), .rst_n(rst_n), .bus(i44));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, s[7:0]}.
  function automatic logic [9:0] ref_op(input int w, input int a, input int b,
                                        input int cin, input int sub);
    int m, half, u, sa, sb, t;
    logic co, ov;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (sub == 0) begin
      u  = a + b + cin;
      co = (u >= m);
      t  = sa + sb + cin;
    end else begin
      u  = a - b - cin;
      co = (a >= b + cin);
      t  = sa - sb - cin;
    end
    ov = (t < -half) || (t > half - 1);
    return {ov, co, 8'(u & (m - 1))};
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
    i8.a = a; i8.b = b; i8.cin = cin; i8.sub = sub;
    i8.in_valid = 1'b1;
    chk({nm, " in_ready before accept"}, 32'(i8.in_ready), 32'd1);
    edge1();
    i8.in_valid = 1'b0;
    i8.a = 8'hA5; i8.b = 8'h5A; i8.cin = ~cin; i8.sub = ~sub;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      edge1();
      if (i8.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume8(input string nm);
    i8.out_ready = 1'b1;
    edge1();
    i8.out_ready = 1'b0;
    chk({nm, " out_valid after consume"}, 32'(i8.out_valid), 32'd0);
    chk({nm, " in_ready after consume"}, 32'(i8.in_ready), 32'd1);
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub, input logic [9:0] e);
    int lat;
    accept8(nm, a, b, cin, sub);
    wait8(lat);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " s"}, 32'(i8.s), 32'(e[7:0]));
    chk({nm, " cout"}, 32'(i8.cout), 32'(e[8]));
    chk({nm, " ovf"}, 32'(i8.ovf), 32'(e[9]));
    chk({nm, " in_ready in hold"}, 32'(i8.in_ready), 32'd0);
    consume8(nm);
  endtask

  task automatic run4(input int a, input int b, input int cin, input int sub);
    logic [9:0] e;
    int l1, l2, l4;
    string nm;
    e  = ref_op(4, a, b, cin, sub);
    nm = $sformatf("w4 a=%0h b=%0h c=%0d sub=%0d", a, b, cin, sub);
    i41.a = 4'(a); i41.b = 4'(b); i41.cin = 1'(cin); i41.sub = 1'(sub); i41.in_valid = 1'b1;
    i42.a = 4'(a); i42.b = 4'(b); i42.cin = 1'(cin); i42.sub = 1'(sub); i42.in_valid = 1'b1;
    i44.a = 4'(a); i44.b = 4'(b); i44.cin = 1'(cin); i44.sub = 1'(sub); i44.in_valid = 1'b1;
    edge1();
    i41.in_valid = 1'b0; i42.in_valid = 1'b0; i44.in_valid = 1'b0;
    l1 = 0; l2 = 0; l4 = 0;
    for (int n = 1; n <= 6; n++) begin
      edge1();
      if (l1 == 0 && i41.out_valid) l1 = n;
      if (l2 == 0 && i42.out_valid) l2 = n;
      if (l4 == 0 && i44.out_valid) l4 = n;
    end
    chk({nm, " d1 lat"}, 32'(l1), 32'd4);
    chk({nm, " d2 lat"}, 32'(l2), 32'd2);
    chk({nm, " d4 lat"}, 32'(l4), 32'd1);
    chk({nm, " d1 res"}, 32'({i41.ovf, i41.cout, i41.s}), 32'({e[9:8], e[3:0]}));
    chk({nm, " d2 res"}, 32'({i42.ovf, i42.cout, i42.s}), 32'({e[9:8], e[3:0]}));
    chk({nm, " d4 res"}, 32'({i44.ovf, i44.cout, i44.s}), 32'({e[9:8], e[3:0]}));
    i41.out_ready = 1'b1; i42.out_ready = 1'b1; i44.out_ready = 1'b1;
    edge1();
    i41.out_ready = 1'b0; i42.out_ready = 1'b0; i44.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb, s_hold;
    logic rc, rs;

    n_cmp = 0;
    n_bad = 0;
    tbl[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h40, 8'hC0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    i8.in_valid = 0;  i8.a = 0;  i8.b = 0;  i8.cin = 0;  i8.sub = 0;  i8.out_ready = 0;
    i41.in_valid = 0; i41.a = 0; i41.b = 0; i41.cin = 0; i41.sub = 0; i41.out_ready = 0;
    i42.in_valid = 0; i42.a = 0; i42.b = 0; i42.cin = 0; i42.sub = 0; i42.out_ready = 0;
    i44.in_valid = 0; i44.a = 0; i44.b = 0; i44.cin = 0; i44.sub = 0; i44.out_ready = 0;

    rst_n = 1'b0;
    #12;
    chk("reset in_ready", 32'(i8.in_ready), 32'd1);
    chk("reset out_valid", 32'(i8.out_valid), 32'd0);
    chk("reset s/cout/ovf", 32'({i8.ovf, i8.cout, i8.s}), 32'd0);
    edge1();
    rst_n = 1'b1;
    edge1();

    for (int i = 0; i < 8; i++)
      run8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
           {tbl[i].ovf, tbl[i].cout, tbl[i].s});

    // Backpressure: result must hold, extra in_valid ignored.
    accept8("bp", 8'h21, 8'h13, 1'b0, 1'b0);
    wait8(lat);
    chk("bp latency", 32'(lat), 32'd8);
    s_hold = i8.s;
    chk("bp s", 32'(s_hold), 32'h34);
    for (int k = 0; k < 5; k++) begin
      i8.in_valid = 1'b1; i8.a = 8'(k * 17); i8.b = 8'h77;
      edge1();
      chk($sformatf("bp hold%0d out_valid", k), 32'(i8.out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(i8.in_ready), 32'd0);
      chk($sformatf("bp hold%0d s", k), 32'(i8.s), 32'(s_hold));
    end
    i8.a = 8'h01; i8.b = 8'h02; i8.cin = 1'b0; i8.sub = 1'b0;
    i8.out_ready = 1'b1;
    edge1();
    i8.out_ready = 1'b0;
    chk("bp release out_valid", 32'(i8.out_valid), 32'd0);
    chk("bp release in_ready", 32'(i8.in_ready), 32'd1);
    chk("bp s kept after consume", 32'(i8.s), 32'(s_hold));
    edge1();
    i8.in_valid = 1'b0;
    chk("bp next accepted", 32'(i8.in_ready), 32'd0);
    wait8(lat);
    chk("bp next latency", 32'(lat), 32'd8);
    chk("bp next s", 32'(i8.s), 32'h03);
    consume8("bp next");

    // Asynchronous reset in the middle of RUN.
    accept8("rst", 8'h3C, 8'h0F, 1'b1, 1'b0);
    edge1();
    edge1();
    edge1();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(i8.in_ready), 32'd1);
    chk("midrst out_valid", 32'(i8.out_valid), 32'd0);
    chk("midrst s", 32'(i8.s), 32'd0);
    chk("midrst cout/ovf", 32'({i8.ovf, i8.cout}), 32'd0);
    edge1();
    rst_n = 1'b1;
    edge1();
    chk("post rst no out_valid", 32'(i8.out_valid), 32'd0);
    run8("post rst add", 8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 1'b0, 8'h30});

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run8($sformatf("rnd%0d", i), ra, rb, rc, rs, ref_op(8, ra, rb, rc, rs));
    end

    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            run4(a, b, c, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
